rggen_bit_field_driver: RTL

- Initiator side of the bit-field access protocol.
- Accepts single host commands over a ready/valid request channel and drives one bit field's access signals (valid, read, write, write data, write mask) plus its hardware clear vector.
- Returns read data and status over a ready/valid response channel.
- Used by bus bridges and test/DFT sequencers to poke individual bit fields, including set-type (write-0/1-to-set) fields with clear inputs.

---
 rtl/rggen_bit_field_driver.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/rggen_bit_field_driver.sv
// Bit-field access initiator: takes one host command at a time over a
// ready/valid request channel, drives a single bit field's access strobes
// and clear vector, and returns read data/status over a ready/valid
// response channel.
// Optional readback verify: define RGGEN_BIT_FIELD_DRIVER_VERIFY_EN.
module rggen_bit_field_driver #(
  parameter int WIDTH     = 8,
  parameter bit SET_VALUE = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_op,
  input  logic [WIDTH-1:0] i_req_data,
  input  logic [WIDTH-1:0] i_req_mask,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_error,
  output logic             o_bf_valid,
  output logic             o_bf_read,
  output logic             o_bf_write,
  output logic [WIDTH-1:0] o_bf_write_data,
  output logic [WIDTH-1:0] o_bf_write_mask,
  input  logic [WIDTH-1:0] i_bf_read_data,
  output logic [WIDTH-1:0] o_clear
);

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

`ifdef RGGEN_BIT_FIELD_DRIVER_VERIFY_EN
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    VERIFY  = 2'b10,
    RESPOND = 2'b11
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RESPOND = 2'b11
  } state_e;
`endif

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic               bf_valid_q, bf_valid_d;
  logic               bf_read_q, bf_read_d;
  logic               bf_write_q, bf_write_d;
  logic [WIDTH-1:0]   bf_wdata_q, bf_wdata_d;
  logic [WIDTH-1:0]   bf_wmask_q, bf_wmask_d;
  logic [WIDTH-1:0]   clear_q, clear_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;

`ifdef RGGEN_BIT_FIELD_DRIVER_VERIFY_EN
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic               rsp_error_q, rsp_error_d;
  logic [WIDTH-1:0]   expect_value;

  // Value the field must hold under the mask after the access.
  always_comb begin
    expect_value = '0;
    case (op_q)
      OP_WRITE: expect_value = data_q;
      OP_SET:   expect_value = '1;
      default:  expect_value = '0;
    endcase
  end
`endif

  // Next-state and next-output logic. The bf/clear strobes are computed one
  // state ahead so that they come straight out of flops during ACCESS/VERIFY.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    bf_valid_d = 1'b0;
    bf_read_d  = 1'b0;
    bf_write_d = 1'b0;
    bf_wdata_d = '0;
    bf_wmask_d = '0;
    clear_d    = '0;
    rsp_data_d = rsp_data_q;
`ifdef RGGEN_BIT_FIELD_DRIVER_VERIFY_EN
    data_d      = data_q;
    mask_d      = mask_q;
    rsp_error_d = rsp_error_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          op_d    = op_e'(i_req_op);
          state_d = ACCESS;
`ifdef RGGEN_BIT_FIELD_DRIVER_VERIFY_EN
          data_d      = i_req_data;
          mask_d      = i_req_mask;
          rsp_error_d = 1'b0;
`endif
          case (op_e'(i_req_op))
            OP_READ: begin
              bf_valid_d = 1'b1;
              bf_read_d  = 1'b1;
            end
            OP_WRITE: begin
              bf_valid_d = 1'b1;
              bf_write_d = 1'b1;
              bf_wdata_d = i_req_data;
              bf_wmask_d = i_req_mask;
            end
            OP_SET: begin
              bf_valid_d = 1'b1;
              bf_write_d = 1'b1;
              bf_wdata_d = SET_VALUE ? i_req_mask : ~i_req_mask;
              bf_wmask_d = i_req_mask;
            end
            default: clear_d = i_req_mask;
          endcase
        end
      end
      ACCESS: begin
        rsp_data_d = (op_q == OP_READ) ? i_bf_read_data : '0;
`ifdef RGGEN_BIT_FIELD_DRIVER_VERIFY_EN
        if (op_q != OP_READ) begin
          state_d    = VERIFY;
          bf_valid_d = 1'b1;
          bf_read_d  = 1'b1;
        end else begin
          state_d = RESPOND;
        end
`else
        state_d = RESPOND;
`endif
      end
`ifdef RGGEN_BIT_FIELD_DRIVER_VERIFY_EN
      VERIFY: begin
        rsp_data_d  = i_bf_read_data;
        rsp_error_d = |((i_bf_read_data ^ expect_value) & mask_q);
        state_d     = RESPOND;
      end
`endif
      RESPOND: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any command in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      bf_valid_q <= 1'b0;
      bf_read_q  <= 1'b0;
      bf_write_q <= 1'b0;
      bf_wdata_q <= '0;
      bf_wmask_q <= '0;
      clear_q    <= '0;
      rsp_data_q <= '0;
`ifdef RGGEN_BIT_FIELD_DRIVER_VERIFY_EN
      data_q      <= '0;
      mask_q      <= '0;
      rsp_error_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      bf_valid_q <= bf_valid_d;
      bf_read_q  <= bf_read_d;
      bf_write_q <= bf_write_d;
      bf_wdata_q <= bf_wdata_d;
      bf_wmask_q <= bf_wmask_d;
      clear_q    <= clear_d;
      rsp_data_q <= rsp_data_d;
`ifdef RGGEN_BIT_FIELD_DRIVER_VERIFY_EN
      data_q      <= data_d;
      mask_q      <= mask_d;
      rsp_error_q <= rsp_error_d;
`endif
    end
  end

  assign o_req_ready     = (state_q == IDLE);
  assign o_rsp_valid     = (state_q == RESPOND);
  assign o_rsp_data      = rsp_data_q;
  assign o_bf_valid      = bf_valid_q;
  assign o_bf_read       = bf_read_q;
  assign o_bf_write      = bf_write_q;
  assign o_bf_write_data = bf_wdata_q;
  assign o_bf_write_mask = bf_wmask_q;
  assign o_clear         = clear_q;
`ifdef RGGEN_BIT_FIELD_DRIVER_VERIFY_EN
  assign o_rsp_error     = rsp_error_q;
`else
  assign o_rsp_error     = 1'b0;
`endif

endmodule
